// File: rtl/mux_input_sequencer.sv
// Operand bank loader and mux-select sweeper feeding the wide operand mux.
// Optional feature macro: MUX_SEQ_REPEAT_EN (re-sweep the retained bank without reloading).

module mux_seq_word #(
  parameter int BIT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 we_i,
  input  logic [BIT_WIDTH-1:0] d_i,
  output logic [BIT_WIDTH-1:0] q_o
);
  logic [BIT_WIDTH-1:0] word_q;

  always_ff @(posedge i_clk) begin
    if (i_reset)   word_q <= '0;
    else if (we_i) word_q <= d_i;
  end

  assign q_o = word_q;
endmodule

module mux_input_sequencer #(
  parameter int BIT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 6,
  parameter int NUM_INPUTS = 1 << SEL_WIDTH
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset,
  input  logic                                 i_load_valid,
  input  logic [BIT_WIDTH-1:0]                 i_load_data,
  output logic                                 o_load_ready,
  output logic                                 o_full,
  input  logic                                 i_start,
  input  logic [SEL_WIDTH:0]                   i_count,
  output logic [NUM_INPUTS-1:0][BIT_WIDTH-1:0] o_inputs,
  output logic [SEL_WIDTH-1:0]                 o_sel,
  output logic                                 o_sel_valid,
  input  logic                                 i_sel_ready,
  output logic                                 o_done
);
  typedef enum logic [1:0] {EMPTY, FULL, SWEEP} state_t;

  localparam logic [SEL_WIDTH:0]   CNT_MAX = (SEL_WIDTH+1)'(NUM_INPUTS);
  localparam logic [SEL_WIDTH-1:0] PTR_END = SEL_WIDTH'(NUM_INPUTS - 1);

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH:0]   cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 load_hs;
  logic [NUM_INPUTS-1:0] we;

  assign load_hs = (state_q == EMPTY) && i_load_valid;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (load_hs) begin
          wr_ptr_d = wr_ptr_q + SEL_WIDTH'(1);
          if (wr_ptr_q == PTR_END) state_d = FULL;
        end
      end
      FULL: begin
        if (i_start) begin
          state_d = SWEEP;
          sel_d   = '0;
          // Zero or oversize counts mean a full sweep of the bank.
          cnt_d   = (i_count == '0 || i_count > CNT_MAX) ? CNT_MAX : i_count;
        end
      end
      SWEEP: begin
        if (i_sel_ready) begin
          if ({1'b0, sel_q} == cnt_q - (SEL_WIDTH+1)'(1)) begin
`ifdef MUX_SEQ_REPEAT_EN
            state_d = FULL;
`else
            state_d = EMPTY;
`endif
            sel_d  = '0;
            done_d = 1'b1;
          end else begin
            sel_d = sel_q + SEL_WIDTH'(1);
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_bank
    assign we[k] = load_hs && (wr_ptr_q == SEL_WIDTH'(k));
    mux_seq_word #(.BIT_WIDTH(BIT_WIDTH)) u_word (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .we_i    (we[k]),
      .d_i     (i_load_data),
      .q_o     (o_inputs[k])
    );
  end

  assign o_load_ready = (state_q == EMPTY);
  assign o_full       = (state_q == FULL);
  assign o_sel_valid  = (state_q == SWEEP);
  assign o_sel        = sel_q;
  assign o_done       = done_q;
endmodule
